// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between a CPU requester and a debug/loader
// requester. A request arriving while the arbiter is idle is granted, the
// owner's command (we/addr/wdata) is captured, and the memory is driven for
// exactly LAT cycles. The owner then receives a one-cycle done pulse, and
// read data stays in that owner's rdata register until its next read
// completes. When both requesters ask in the same idle cycle, the one not
// served last wins.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   cpu_req/cpu_we        CPU request / write enable
//   cpu_addr/cpu_wdata    CPU address / write data
//   cpu_done/cpu_rdata    CPU completion pulse / read data
//   cpu_stall             cpu_req && !cpu_done (combinational)
//   dbg_req/dbg_we        debug request / write enable
//   dbg_addr/dbg_wdata    debug address / write data
//   dbg_done/dbg_rdata    debug completion pulse / read data
//   mem_en/mem_we         memory enable / write enable
//   mem_addr/mem_wdata    memory address / write data
//   mem_rdata             memory read data
//   busy                  high while an access is in progress (ACCESS, DONE)
//   owner                 current owner while busy (0=cpu, 1=dbg), else 0
//
// LAT must be in 1..15 so that the 4-bit cycle counter can hold LAT-1.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_done,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_owner;       // 0=cpu, 1=dbg
    logic          r_last_dbg;    // 1 when dbg was the last port served
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_cnt;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dbg_rdata;

    logic          w_any_req;
    logic          w_grant_dbg;

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_any_req   = cpu_req | dbg_req;
        // dbg wins if it is alone, or if both ask and the cpu was served last
        w_grant_dbg = dbg_req & (~cpu_req | ~r_last_dbg);
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        busy        = 1'b0;
        owner       = 1'b0;
        cpu_done    = 1'b0;
        dbg_done    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = r_we;
                busy   = 1'b1;
                owner  = r_owner;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                owner       = r_owner;
                cpu_done    = ~r_owner;
                dbg_done    = r_owner;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, command latch, counter and read-data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_last_dbg  <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= 4'd0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_dbg;
                        r_cnt   <= CNT_LOAD;
                        if (w_grant_dbg) begin
                            r_we    <= dbg_we;
                            r_addr  <= dbg_addr;
                            r_wdata <= dbg_wdata;
                        end else begin
                            r_we    <= cpu_we;
                            r_addr  <= cpu_addr;
                            r_wdata <= cpu_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!r_we) begin
                        // last memory cycle: read data is valid now
                        if (r_owner) begin
                            r_dbg_rdata <= mem_rdata;
                        end else begin
                            r_cpu_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    r_last_dbg <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_rdata = r_cpu_rdata;
    assign dbg_rdata = r_dbg_rdata;
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter LAT, default 2, memory access cycles; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports cpu_req/cpu_we  input  1 each  CPU access request / write enable.
REQ-007 SHALL have ports cpu_addr  input  AW, cpu_wdata  input  DW  CPU address / write data.
REQ-008 SHALL have ports cpu_done  output  1, cpu_rdata  output  DW, cpu_stall  output  1.
REQ-009 SHALL have ports dbg_req/dbg_we  input  1, dbg_addr  input  AW, dbg_wdata  input  DW  debug/loader requester.
REQ-010 SHALL have ports dbg_done  output  1, dbg_rdata  output  DW.
REQ-011 SHALL have ports mem_en/mem_we  output  1, mem_addr  output  AW, mem_wdata  output  DW, mem_rdata  input  DW  shared single-port memory.
REQ-012 SHALL have ports busy  output  1, owner  output  1 (0=cpu, 1=dbg).

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-014 IDLE: no req -> stay IDLE; any req -> grant, latch owner's we/addr/wdata, load counter LAT-1, go ACCESS.
REQ-015 Single req SHALL be granted directly; both reqs SHALL be granted round-robin: port not served last wins.
REQ-016 last-served register SHALL reset to dbg so cpu wins first tie.
REQ-017 ACCESS: mem_en=1, mem_we/mem_addr/mem_wdata from latched regs, held stable exactly LAT cycles; counter decrements each cycle.
REQ-018 ACCESS with counter==0: on read, capture mem_rdata into owner's rdata register; go DONE.
REQ-019 DONE: mem_en=0; owner's done high exactly one cycle; update last-served; go IDLE.
REQ-020 Latency: req high in IDLE cycle 0 -> mem_en cycles 1..LAT -> done in cycle LAT+1.
REQ-021 Requester SHALL hold req until it samples done, then drop it; arbiter relies on req low in following IDLE cycle.
REQ-022 Writes SHALL leave rdata registers unchanged; rdata held until the next read completion for that port.
REQ-023 Non-owner requests during ACCESS/DONE SHALL be held pending, never dropped or merged.
REQ-024 Owner deasserting req mid-access SHALL NOT abort; access completes and done still pulses.
REQ-025 Input changes after grant SHALL NOT affect mem_addr/mem_we/mem_wdata of the current access.
REQ-026 cpu_stall SHALL be combinational cpu_req AND NOT cpu_done.
REQ-027 busy SHALL be 1 in ACCESS and DONE; owner SHALL be valid while busy, 0 otherwise.
REQ-028 mem_we SHALL be 0 whenever mem_en is 0.

Reset
REQ-029 reset high at an edge SHALL force IDLE regardless of state, including mid-ACCESS.
REQ-030 After reset: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_done=0, dbg_done=0, cpu_rdata=0, dbg_rdata=0, busy=0, owner=0, counter=0.
REQ-031 Access interrupted by reset SHALL produce no done pulse and no rdata update.

Verification
REQ-032 LAT=2, cpu read addr 0x10, mem_rdata=0xDEADBEEF -> mem_en cycles 1-2, cpu_done cycle 3, cpu_rdata=0xDEADBEEF, cpu_stall 1 in cycles 0-2.
REQ-033 cpu and dbg req same IDLE cycle after reset -> cpu served first, dbg granted on next IDLE; dbg_done exactly LAT+2 cycles after cpu_done.
REQ-034 Both requesters continuously re-requesting for 6 accesses -> owner alternates 0,1,0,1,0,1.
REQ-035 dbg write addr 0x20 data 0x1234, cpu_addr toggling during access -> mem_addr=0x20, mem_we=1 for LAT cycles, rdata regs unchanged.
REQ-036 reset asserted in second ACCESS cycle with LAT=4 -> next cycle all outputs at reset values, no done pulse, then fresh cpu read completes normally.
